ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
- Instruction prefetch stage directly upstream of the CPU core's decode stage.
- Issues sequential word fetches to the memory interface using a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents them to decode through a valid/ready interface.
- Handles branch redirects by flushing the FIFO, discarding any in-flight response and restarting fetch at the new address.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADR_W, 32, instruction address width.
- DATA_W, 32, instruction word width.
- RESET_PC, 32'h0, fetch address after reset.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous reset, active-high.
- mem_req  out  1  fetch request.
- mem_adr  out  ADR_W  word address; bits [1:0] always 0.
- mem_ack  in  1  request completed; mem_data and mem_err are valid this cycle.
- mem_data  in  DATA_W  returned instruction.
- mem_err  in  1  bus error, qualified by mem_ack.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode accepts the FIFO head.
- instr_data  out  DATA_W  FIFO head instruction.
- instr_adr  out  ADR_W  address of the FIFO head.
- redirect_valid  in  1  flush the queue and restart fetch.
- redirect_adr  in  ADR_W  new fetch address; bits [1:0] ignored and forced to 0.
- fetch_fault  out  1  sticky bus-error indication.

Behaviour:
- Reset values while rst is high: mem_req=0, mem_adr=RESET_PC, instr_valid=0, instr_data=0, instr_adr=0, fetch_fault=0, FIFO count=0, fetch_pc=RESET_PC, state=IDLE.
- States: IDLE, REQ, DISCARD, HOLD, FAULT.
- IDLE: entered for exactly one cycle after reset deasserts, then goes to REQ.
- REQ: mem_req=1 and mem_adr=fetch_pc. Both stay stable until mem_ack.
  - On mem_ack with mem_err=0: push {fetch_pc, mem_data}, then fetch_pc += 4.
  - Next state is REQ if count after push < DEPTH, otherwise HOLD.
  - mem_req deasserts for one cycle between requests; at most one request is outstanding.
- HOLD: mem_req=0. Returns to REQ in the cycle after a pop makes count < DEPTH.
- Redirect: redirect_valid has priority over every other event in the same cycle.
  - FIFO is flushed (count=0, instr_valid=0 next cycle) and fetch_pc = redirect_adr.
  - If mem_req=1 and mem_ack=0: go to DISCARD. mem_req stays high at the old address until ack, the response is dropped, then go to REQ at the new fetch_pc.
  - If mem_ack=1 in the same cycle: the data is dropped and the next state is REQ.
  - From HOLD, IDLE or FAULT: go to REQ. fetch_fault clears.
- Fault: mem_ack with mem_err=1 in REQ goes to FAULT.
  - No push; fetch_fault=1; mem_req=0.
  - Entries already in the FIFO stay drainable.
  - Only a redirect or reset leaves FAULT.
- Redirect during DISCARD: fetch_pc updates and the state stays DISCARD.
- FIFO:
  - Circular read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - Pop when instr_valid & instr_ready.
  - Simultaneous push and pop keeps count unchanged and is legal at any count.
  - A push is never issued when count==DEPTH.
  - instr_data and instr_adr hold the head entry and are don't-care when instr_valid=0.
- Latency, without the optional feature: instruction visible on instr_valid in the cycle after mem_ack.
- fetch_pc addition wraps modulo 2^ADR_W with no fault.
- Reset asserted mid-handshake: mem_req drops immediately (asynchronous) and all state returns to reset values.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- When defined: if the FIFO is empty, state is REQ, mem_ack=1, mem_err=0 and redirect_valid=0, then instr_valid=1 combinationally in the same cycle.
  - instr_data=mem_data and instr_adr=fetch_pc.
  - If instr_ready=1 that cycle, the word is consumed and not written into the FIFO; otherwise it is pushed normally.
- When undefined: no combinational path from mem_* to instr_*; minimum latency is 1 cycle after mem_ack.

Test Plan:
- Reset, then memory acks every request 2 cycles after mem_req with data = address ^ 32'hA5A5A5A5, instr_ready=1 -> mem_adr sequence 0x0, 0x4, 0x8; decode receives 0xA5A5A5A5, 0xA5A5A5A1, 0xA5A5A5AD in order with matching instr_adr.
- instr_ready=0, memory acks in 1 cycle -> exactly 4 pushes, state HOLD, mem_req=0; one pop -> single new request at 0x10.
- redirect_adr=0x100 asserted while mem_req=1 and ack pending 3 cycles -> old response discarded, next mem_adr=0x100, first delivered instr_adr=0x100, FIFO empty in between.
- redirect and mem_ack in the same cycle, with instr_ready=1 and a valid head -> no pop counted, acked data dropped, count=0, next request at redirect address.
- mem_err=1 on the ack for 0x8 -> fetch_fault=1, mem_req stays 0, entries 0x0 and 0x4 still delivered; redirect to 0x40 -> fetch_fault=0, fetch resumes at 0x40.
- rst pulsed while mem_req=1 -> mem_req=0 in the same cycle; after release, first request at RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
//------------------------------------------------------------------------------
// Module   : ifetch_queue
// Purpose  : Sequential instruction prefetcher with a small FIFO toward decode.
//            Optional macro IFQ_BYPASS_EN adds a same-cycle memory-to-decode path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifetch_queue #(
  parameter int               DEPTH    = 4,
  parameter int               ADR_W    = 32,
  parameter int               DATA_W   = 32,
  parameter logic [ADR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADR_W-1:0]  mem_adr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_err,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADR_W-1:0]  instr_adr,
  input  logic              redirect_valid,
  input  logic [ADR_W-1:0]  redirect_adr,
  output logic              fetch_fault
);

  localparam int c_AW = $clog2(DEPTH);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_REQ     = 3'd1;
  localparam logic [2:0] c_ST_DISCARD = 3'd2;
  localparam logic [2:0] c_ST_HOLD    = 3'd3;
  localparam logic [2:0] c_ST_FAULT   = 3'd4;

  localparam logic [c_AW:0]    c_CNT_ONE = (c_AW+1)'(1);
  localparam logic [c_AW:0]    c_FULL    = (c_AW+1)'(DEPTH);
  localparam logic [c_AW-1:0]  c_PTR_ONE = c_AW'(1);
  localparam logic [ADR_W-1:0] c_PC_STEP = ADR_W'(4);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_gap;
  logic              w_gap_nxt;
  logic [ADR_W-1:0]  r_fetch_pc;
  logic [ADR_W-1:0]  r_disc_adr;
  logic              r_fault;

  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [c_AW:0]     r_count;
  logic [c_AW:0]     w_count_nxt;
  logic [ADR_W-1:0]  r_adr_mem  [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];

  logic              w_mem_req;
  logic              w_ack_any;
  logic              w_ack_ok;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass_take;
  logic [ADR_W-1:0]  w_redir_pc;
  logic              w_unused;

  assign w_unused   = &{1'b0, redirect_adr[1:0]};
  assign w_redir_pc = {redirect_adr[ADR_W-1:2], 2'b00};

  // r_gap forces the one idle cycle between back-to-back requests
  assign w_mem_req    = ((r_state == c_ST_REQ) && !r_gap) || (r_state == c_ST_DISCARD);
  assign w_ack_any    = (r_state == c_ST_REQ) && w_mem_req && mem_ack;
  assign w_ack_ok     = w_ack_any && !mem_err && !redirect_valid;
  assign w_fifo_empty = (r_count == '0);

`ifdef IFQ_BYPASS_EN
  logic w_byp_valid;
  assign w_byp_valid   = w_ack_ok && w_fifo_empty;
  assign w_bypass_take = w_byp_valid && instr_ready;
  assign instr_valid   = !w_fifo_empty || w_byp_valid;
  assign instr_data    = w_byp_valid ? mem_data   : r_data_mem[r_rptr];
  assign instr_adr     = w_byp_valid ? r_fetch_pc : r_adr_mem[r_rptr];
`else
  assign w_bypass_take = 1'b0;
  assign instr_valid   = !w_fifo_empty;
  assign instr_data    = r_data_mem[r_rptr];
  assign instr_adr     = r_adr_mem[r_rptr];
`endif

  assign w_push = w_ack_ok && !w_bypass_take;
  assign w_pop  = !w_fifo_empty && instr_ready && !redirect_valid;

  assign mem_req     = w_mem_req;
  assign mem_adr     = (r_state == c_ST_DISCARD) ? r_disc_adr : r_fetch_pc;
  assign fetch_fault = r_fault;

  always_comb begin
    w_count_nxt = r_count;
    if (redirect_valid) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_CNT_ONE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_state_nxt = c_ST_REQ;
      end
      c_ST_REQ: begin
        if (redirect_valid) begin
          if (w_mem_req && !mem_ack) begin
            w_state_nxt = c_ST_DISCARD;
          end else begin
            w_state_nxt = c_ST_REQ;
            w_gap_nxt   = w_mem_req && mem_ack;
          end
        end else if (w_mem_req && mem_ack) begin
          if (mem_err) begin
            w_state_nxt = c_ST_FAULT;
          end else if (w_count_nxt < c_FULL) begin
            w_state_nxt = c_ST_REQ;
            w_gap_nxt   = 1'b1;
          end else begin
            w_state_nxt = c_ST_HOLD;
          end
        end
      end
      c_ST_DISCARD: begin
        // the stale response closes the old handshake; fetch restarts at fetch_pc
        if (mem_ack) begin
          w_state_nxt = c_ST_REQ;
          w_gap_nxt   = 1'b1;
        end
      end
      c_ST_HOLD: begin
        if (redirect_valid || w_pop) begin
          w_state_nxt = c_ST_REQ;
        end
      end
      c_ST_FAULT: begin
        if (redirect_valid) begin
          w_state_nxt = c_ST_REQ;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_gap      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_disc_adr <= RESET_PC;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
      end else if (w_ack_any && !mem_err) begin
        r_fetch_pc <= r_fetch_pc + c_PC_STEP;
      end
      if (redirect_valid && (r_state == c_ST_REQ) && w_mem_req && !mem_ack) begin
        r_disc_adr <= r_fetch_pc;
      end
      if (redirect_valid) begin
        r_fault <= 1'b0;
      end else if (w_ack_any && mem_err) begin
        r_fault <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_adr_mem[i]  <= '0;
        r_data_mem[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (redirect_valid) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) begin
          r_adr_mem[r_wptr]  <= r_fetch_pc;
          r_data_mem[r_wptr] <= mem_data;
          r_wptr             <= r_wptr + c_PTR_ONE;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + c_PTR_ONE;
        end
      end
    end
  end

endmodule

`default_nettype wire
